// File: rtl/mem_arbiter_if.sv
// Bus bundle for the memory arbiter: instruction-fetch port, data port and
// the shared memory port. The arbiter takes the slave view; the environment
// (CPU front-end, LSU and memory) drives the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  // Instruction-fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_valid;
  logic [DATA_W-1:0] i_rdata;

  // Data load/store port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  // Shared memory port
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  m_ack, m_rdata,
    output i_gnt, i_valid, i_rdata,
    output d_gnt, d_valid, d_rdata,
    output m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output m_ack, m_rdata,
    input  i_gnt, i_valid, i_rdata,
    input  d_gnt, d_valid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share a
// single memory. One transaction is outstanding at a time; when both ports
// ask in the same cycle, ownership alternates using the last_d history bit.
// Every output comes straight from a flop.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t            state_q,   state_d;
  logic              last_d_q,  last_d_d;
  logic              m_req_q,   m_req_d;
  logic              m_we_q,    m_we_d;
  logic [ADDR_W-1:0] m_addr_q,  m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              i_gnt_q,   i_gnt_d;
  logic              d_gnt_q,   d_gnt_d;
  logic              i_valid_q, i_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  // A port whose valid is currently high is finishing its previous access,
  // so its request is not considered this cycle.
  logic i_take;
  logic d_take;

  // Next-state logic: arbitration in IDLE, completion on m_ack in BUSY, and
  // a full freeze (valid pulse included) whenever clk_en is low.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_gnt_d   = i_gnt_q;
    d_gnt_d   = d_gnt_q;
    i_valid_d = i_valid_q;
    d_valid_d = d_valid_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_take    = bus.i_req && !i_valid_q;
    d_take    = bus.d_req && !d_valid_q;

    if (clk_en) begin
      i_valid_d = 1'b0;
      d_valid_d = 1'b0;

      case (state_q)
        IDLE: begin
          if (d_take && (!i_take || !last_d_q)) begin
            state_d   = BUSY_D;
            last_d_d  = 1'b1;
            m_req_d   = 1'b1;
            m_we_d    = bus.d_we;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
            d_gnt_d   = 1'b1;
          end else if (i_take) begin
            state_d   = BUSY_I;
            last_d_d  = 1'b0;
            m_req_d   = 1'b1;
            m_we_d    = 1'b0;
            m_addr_d  = bus.i_addr;
            i_gnt_d   = 1'b1;
          end
        end

        BUSY_I: begin
          if (bus.m_ack) begin
            state_d   = IDLE;
            i_rdata_d = bus.m_rdata;
            i_valid_d = 1'b1;
            i_gnt_d   = 1'b0;
            m_req_d   = 1'b0;
          end
        end

        BUSY_D: begin
          if (bus.m_ack) begin
            state_d   = IDLE;
            if (!m_we_q) begin
              d_rdata_d = bus.m_rdata;
            end
            d_valid_d = 1'b1;
            d_gnt_d   = 1'b0;
            m_req_d   = 1'b0;
          end
        end

        default: begin
          state_d = IDLE;
          i_gnt_d = 1'b0;
          d_gnt_d = 1'b0;
          m_req_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset wins regardless of clk_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_gnt_q   <= i_gnt_d;
      d_gnt_q   <= d_gnt_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_gnt   = i_gnt_q;
  assign bus.d_gnt   = d_gnt_q;
  assign bus.i_valid = i_valid_q;
  assign bus.d_valid = d_valid_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

endmodule
